// File: rtl/core_general_pkg.sv
// Shared core definitions: data/op widths, decoded-op field positions,
// ALU function codes and the execute/memory pipeline register layout.
package core_general_pkg;

  localparam int XLEN  = 32;
  localparam int OPLEN = 10;

  // decoded_op field positions
  localparam int FUNCT3_BIT_M    = 2;
  localparam int FUNCT3_BIT_L    = 0;
  localparam int USE_ALU_IN1_BIT = 3;
  localparam int USE_ALU_IN2_BIT = 4;
  localparam int MUST_JUMP_BIT   = 5;

  // Low three bits of funct_alu; bit 3 selects SUB over ADD and SRA over SRL.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // Branch/compare condition carried in FUNCT3.
  typedef enum logic [2:0] {
    CMP_EQ   = 3'b000,
    CMP_NE   = 3'b001,
    CMP_SLTI = 3'b010,
    CMP_SLTU = 3'b011,
    CMP_LT   = 3'b100,
    CMP_GE   = 3'b101,
    CMP_LTU  = 3'b110,
    CMP_GEU  = 3'b111
  } cmp_op_e;

  // Execute -> memory-access pipeline register.
  typedef struct packed {
    logic [OPLEN-1:0] decoded_op;
    logic [4:0]       rdsel;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  rs2data;
    logic [XLEN-1:0]  alu_out;
    logic             jump_state;
  } em_t;

endpackage

// File: rtl/top_execute_alu.sv
// alu: purely combinational integer ALU.
//   aluin1, aluin2 : operands (XLEN)
//   funct_alu      : [2:0] operation, [3] SUB / SRA select
//   aluout         : result (XLEN), wraps modulo 2^XLEN
module alu
  import core_general_pkg::*;
(
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  input  logic [3:0]      funct_alu,
  output logic [XLEN-1:0] aluout
);

  logic [4:0] shamt;
  logic       alt;
  logic       slt;
  logic       sltu;

  assign shamt = aluin2[4:0];
  assign alt   = funct_alu[3];
  assign slt   = $signed(aluin1) < $signed(aluin2);
  assign sltu  = aluin1 < aluin2;

  always_comb begin
    aluout = '0;
    case (funct_alu[2:0])
      ALU_ADD:  aluout = alt ? aluin1 - aluin2 : aluin1 + aluin2;
      ALU_SLL:  aluout = aluin1 << shamt;
      ALU_SLT:  aluout = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU: aluout = {{(XLEN-1){1'b0}}, sltu};
      ALU_XOR:  aluout = aluin1 ^ aluin2;
      ALU_SR:   aluout = alt ? XLEN'($signed(aluin1) >>> shamt) : aluin1 >> shamt;
      ALU_OR:   aluout = aluin1 | aluin2;
      ALU_AND:  aluout = aluin1 & aluin2;
      default:  aluout = '0;
    endcase
  end

endmodule

// File: rtl/top_execute.sv
// top_execute: execute stage. Selects ALU operands, evaluates the ALU and the
// branch comparator, and captures results into the E/M register while
// phase_execute is high.
//   clk, rst_n          : clock; asynchronous active-high reset (clears E/M)
//   phase_*             : state-machine phases; only phase_execute is used
//   imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de : operands
//   funct_alu, rdsel_de, decoded_op_de                   : control
//   *_em                : registered E/M outputs
//   stall_execute       : always 0, execute completes in one cycle
//   aluin1, aluin2, aluout_pre, comp_out, jump_state_pre : observation
module top_execute
  import core_general_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_fetch,
  input  logic             phase_decode,
  input  logic             phase_execute,
  input  logic             phase_memoryaccess,
  input  logic             phase_writeback,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1data_de,
  input  logic [XLEN-1:0]  rs2data_de,
  input  logic [XLEN-1:0]  curr_pc_de,
  input  logic [XLEN-1:0]  next_pc_de,
  input  logic [3:0]       funct_alu,
  input  logic [4:0]       rdsel_de,
  input  logic [OPLEN-1:0] decoded_op_de,
  output logic [OPLEN-1:0] decoded_op_em,
  output logic [4:0]       rdsel_em,
  output logic [XLEN-1:0]  next_pc_em,
  output logic [XLEN-1:0]  rs2data_em,
  output logic [XLEN-1:0]  alu_out_em,
  output logic             jump_state_em,
  output logic             stall_execute,
  output logic [XLEN-1:0]  aluin1,
  output logic [XLEN-1:0]  aluin2,
  output logic [XLEN-1:0]  aluout_pre,
  output logic             comp_out,
  output logic             jump_state_pre
);

  logic unused_phases;
  assign unused_phases = ^{phase_fetch, phase_decode, phase_memoryaccess, phase_writeback};

  logic [2:0] funct3;
  assign funct3 = decoded_op_de[FUNCT3_BIT_M:FUNCT3_BIT_L];

  assign aluin1 = decoded_op_de[USE_ALU_IN1_BIT] ? rs1data_de : curr_pc_de;
  assign aluin2 = decoded_op_de[USE_ALU_IN2_BIT] ? rs2data_de : imm;

  alu u_alu (
    .aluin1    (aluin1),
    .aluin2    (aluin2),
    .funct_alu (funct_alu),
    .aluout    (aluout_pre)
  );

  // Branches compare the raw register values; the set-less-than forms
  // compare rs1 against the selected second operand (register or imm).
  always_comb begin
    comp_out = 1'b0;
    case (funct3)
      CMP_EQ:   comp_out = rs1data_de == rs2data_de;
      CMP_NE:   comp_out = rs1data_de != rs2data_de;
      CMP_LT:   comp_out = $signed(rs1data_de) <  $signed(rs2data_de);
      CMP_GE:   comp_out = $signed(rs1data_de) >= $signed(rs2data_de);
      CMP_LTU:  comp_out = rs1data_de <  rs2data_de;
      CMP_GEU:  comp_out = rs1data_de >= rs2data_de;
      CMP_SLTI: comp_out = $signed(rs1data_de) < $signed(aluin2);
      CMP_SLTU: comp_out = rs1data_de < aluin2;
      default:  comp_out = 1'b0;
    endcase
  end

  assign jump_state_pre = comp_out | decoded_op_de[MUST_JUMP_BIT];
  assign stall_execute  = 1'b0;

  em_t em_d, em_q;

  always_comb begin
    em_d            = '0;
    em_d.decoded_op = decoded_op_de;
    em_d.rdsel      = rdsel_de;
    em_d.next_pc    = next_pc_de;
    em_d.rs2data    = rs2data_de;
    em_d.alu_out    = aluout_pre;
    em_d.jump_state = jump_state_pre;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)              em_q <= '0;
    else if (phase_execute) em_q <= em_d;
  end

  assign decoded_op_em = em_q.decoded_op;
  assign rdsel_em      = em_q.rdsel;
  assign next_pc_em    = em_q.next_pc;
  assign rs2data_em    = em_q.rs2data;
  assign alu_out_em    = em_q.alu_out;
  assign jump_state_em = em_q.jump_state;

endmodule

// File: tb/tb_top_execute.sv
// Directed bench for top_execute with hand-computed expected values.
module tb_top_execute;
  import core_general_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             phase_fetch, phase_decode, phase_execute;
  logic             phase_memoryaccess, phase_writeback;
  logic [XLEN-1:0]  imm, rs1data_de, rs2data_de, curr_pc_de, next_pc_de;
  logic [3:0]       funct_alu;
  logic [4:0]       rdsel_de;
  logic [OPLEN-1:0] decoded_op_de;
  logic [OPLEN-1:0] decoded_op_em;
  logic [4:0]       rdsel_em;
  logic [XLEN-1:0]  next_pc_em, rs2data_em, alu_out_em;
  logic             jump_state_em, stall_execute;
  logic [XLEN-1:0]  aluin1, aluin2, aluout_pre;
  logic             comp_out, jump_state_pre;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  top_execute dut (
    .clk(clk), .rst_n(rst_n),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode),
    .phase_execute(phase_execute), .phase_memoryaccess(phase_memoryaccess),
    .phase_writeback(phase_writeback),
    .imm(imm), .rs1data_de(rs1data_de), .rs2data_de(rs2data_de),
    .curr_pc_de(curr_pc_de), .next_pc_de(next_pc_de),
    .funct_alu(funct_alu), .rdsel_de(rdsel_de), .decoded_op_de(decoded_op_de),
    .decoded_op_em(decoded_op_em), .rdsel_em(rdsel_em), .next_pc_em(next_pc_em),
    .rs2data_em(rs2data_em), .alu_out_em(alu_out_em), .jump_state_em(jump_state_em),
    .stall_execute(stall_execute), .aluin1(aluin1), .aluin2(aluin2),
    .aluout_pre(aluout_pre), .comp_out(comp_out), .jump_state_pre(jump_state_pre)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one execute-phase operation and wait until just after the capture edge.
  task automatic run(input logic [9:0] op, input logic [3:0] f,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] pc, input logic [31:0] im);
    decoded_op_de = op; funct_alu = f;
    rs1data_de = r1; rs2data_de = r2; curr_pc_de = pc; imm = im;
    phase_execute = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    {phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback} = '0;
    imm = '0; rs1data_de = '0; rs2data_de = '0; curr_pc_de = '0; next_pc_de = '0;
    funct_alu = '0; rdsel_de = '0; decoded_op_de = '0;

    // reset state
    @(posedge clk); #1;
    chk("rst_op",   32'(decoded_op_em), 32'h0);
    chk("rst_alu",  alu_out_em,         32'h0);
    chk("rst_jump", 32'(jump_state_em), 32'h0);
    chk("stall",    32'(stall_execute), 32'h0);
    rst_n = 1'b0;

    // passthrough: op 0x155 -> funct3=101 (GE), IN2=rs2, IN1=pc
    next_pc_de = 32'hA0A0A0A0; rdsel_de = 5'b10101;
    run(10'h155, 4'b0000, 32'h0, 32'h10101010, 32'h0, 32'h0);
    chk("pt_op",    32'(decoded_op_em), 32'h155);
    chk("pt_rd",    32'(rdsel_em),      32'h15);
    chk("pt_npc",   next_pc_em,         32'hA0A0A0A0);
    chk("pt_rs2",   rs2data_em,         32'h10101010);
    chk("pt_alu",   alu_out_em,         32'h10101010);
    chk("pt_jump",  32'(jump_state_em), 32'h0);

    // rs operands
    run(10'h018, 4'b0000, 32'hA0A0A0A0, 32'h0A0A0A0A, 32'h0, 32'h0);
    chk("add_rs",   alu_out_em, 32'hAAAAAAAA);
    chk("in1_rs",   aluin1,     32'hA0A0A0A0);
    chk("in2_rs",   aluin2,     32'h0A0A0A0A);
    run(10'h018, 4'b0100, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0, 32'h0);
    chk("xor_rs",   alu_out_em, 32'h0F0F0F0F);

    // pc / imm operands
    run(10'h000, 4'b0000, 32'h5, 32'h7, 32'h10101010, 32'h01010101);
    chk("add_pc",   alu_out_em, 32'h11111111);
    chk("in1_pc",   aluin1,     32'h10101010);
    chk("in2_imm",  aluin2,     32'h01010101);
    run(10'h000, 4'b0100, 32'h0, 32'h0, 32'hFFFF1234, 32'hF0F0F0F0);
    chk("xor_pc",   alu_out_em, 32'h0F0FE2C4);

    // remaining ALU ops, wrap and shift-amount masking
    run(10'h018, 4'b1000, 32'h5, 32'h7, 32'h0, 32'h0);
    chk("sub_wrap", alu_out_em, 32'hFFFFFFFE);
    run(10'h008, 4'b1101, 32'h80000000, 32'h0, 32'h0, 32'h24);
    chk("sra",      alu_out_em, 32'hF8000000);
    run(10'h008, 4'b0101, 32'h80000000, 32'h0, 32'h0, 32'h24);
    chk("srl",      alu_out_em, 32'h08000000);
    run(10'h008, 4'b1001, 32'h1, 32'h0, 32'h0, 32'h1F);
    chk("sll",      alu_out_em, 32'h80000000);
    run(10'h018, 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("slt",      alu_out_em, 32'h1);
    run(10'h018, 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("sltu",     alu_out_em, 32'h0);
    run(10'h018, 4'b0110, 32'hF0F00000, 32'h0000F0F0, 32'h0, 32'h0);
    chk("or",       alu_out_em, 32'hF0F0F0F0);
    run(10'h018, 4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0);
    chk("and",      alu_out_em, 32'h0F000F00);

    // branches
    run(10'h018, 4'b0000, 32'h5, 32'h5, 32'h0, 32'h0);
    chk("beq_eq",   32'(jump_state_em), 32'h1);
    run(10'h018, 4'b0000, 32'h5, 32'h6, 32'h0, 32'h0);
    chk("beq_ne",   32'(jump_state_em), 32'h0);
    run(10'h019, 4'b0000, 32'h5, 32'h6, 32'h0, 32'h0);
    chk("bne",      32'(jump_state_em), 32'h1);
    run(10'h01E, 4'b0000, 32'h1, 32'hA0A0A0A0, 32'h0, 32'h0);
    chk("bltu_lt",  32'(jump_state_em), 32'h1);
    run(10'h01E, 4'b0000, 32'hA0A0A0A0, 32'hA0A0A0A0, 32'h0, 32'h0);
    chk("bltu_eq",  32'(jump_state_em), 32'h0);
    run(10'h01C, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("blt",      32'(jump_state_em), 32'h1);
    run(10'h01D, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
    chk("bge",      32'(jump_state_em), 32'h0);
    run(10'h01F, 4'b0000, 32'h1, 32'hA0A0A0A0, 32'h0, 32'h0);
    chk("bgeu",     32'(jump_state_em), 32'h0);

    // set-less-than against imm, and MUST_JUMP
    run(10'h002, 4'b0010, 32'hA, 32'h0, 32'h0, 32'hF);
    chk("slti_1",   32'(jump_state_em), 32'h1);
    run(10'h002, 4'b0010, 32'hA, 32'h0, 32'h0, 32'h1);
    chk("slti_0",   32'(jump_state_em), 32'h0);
    run(10'h022, 4'b0010, 32'hA, 32'h0, 32'h0, 32'h1);
    chk("mustjump", 32'(jump_state_em), 32'h1);
    run(10'h003, 4'b0011, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1);
    chk("sltiu",    32'(jump_state_em), 32'h0);

    // hold: state from the last capture must survive input changes
    phase_execute = 1'b0;
    decoded_op_de = 10'h3FF; rdsel_de = 5'h1F; next_pc_de = 32'h12345678;
    rs1data_de = 32'h1; rs2data_de = 32'h1; imm = 32'h0; funct_alu = 4'b0000;
    repeat (2) @(posedge clk); #1;
    chk("hold_op",  32'(decoded_op_em), 32'h003);
    chk("hold_rd",  32'(rdsel_em),      32'h15);
    chk("hold_npc", next_pc_em,         32'hA0A0A0A0);
    chk("hold_rs2", rs2data_em,         32'h0);
    chk("hold_jmp", 32'(jump_state_em), 32'h0);

    // asynchronous reset mid-operation, between clock edges
    run(10'h018, 4'b0000, 32'h2, 32'h3, 32'h0, 32'h0);
    chk("pre_rst",  alu_out_em, 32'h5);
    phase_execute = 1'b1;
    rs1data_de = 32'h10; rs2data_de = 32'h20;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("arst_alu", alu_out_em,         32'h0);
    chk("arst_op",  32'(decoded_op_em), 32'h0);
    chk("arst_rd",  32'(rdsel_em),      32'h0);
    chk("arst_npc", next_pc_em,         32'h0);
    chk("comb_rst", aluout_pre,         32'h30);
    @(posedge clk); #1;
    chk("rst_hold", alu_out_em,         32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", alu_out_em,         32'h30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
